// File: rtl/reg_writeback_buffer.sv
// -----------------------------------------------------------------------------
// reg_writeback_buffer
//
// Holds register-file writebacks in an in-order FIFO of {rd, data} until the
// register-file write port is free. The head drains one entry per cycle
// whenever the port is available. Reads from the register file are forwarded
// from the youngest buffered write to the same register, so consumers see
// values that have not landed yet.
//
// Ports
//   clk            : single clock, all state changes on the rising edge
//   reset          : synchronous, active-high
//   in_valid       : writeback request present
//   in_ready       : buffer accepts the request this cycle
//   in_rd          : destination register index (x0 requests are dropped)
//   in_data        : destination write value
//   hold           : register-file write port busy, head is frozen
//   flush          : discard every buffered, not-yet-written request
//   RegWrite       : register-file write enable
//   Rd             : register-file write index (FIFO head)
//   Write_data     : register-file write value (FIFO head)
//   Rs1, Rs2       : read indices, passed through to the register file
//   rf_read_data1/2: raw register-file read data
//   read_data1/2   : forwarded read data
//   pending        : number of buffered entries
// -----------------------------------------------------------------------------
module reg_writeback_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [4:0]               in_rd,
   input  logic [31:0]              in_data,
   input  logic                     hold,
   input  logic                     flush,
   output logic                     RegWrite,
   output logic [4:0]               Rd,
   output logic [31:0]              Write_data,
   input  logic [4:0]               Rs1,
   input  logic [4:0]               Rs2,
   input  logic [31:0]              rf_read_data1,
   input  logic [31:0]              rf_read_data2,
   output logic [31:0]              read_data1,
   output logic [31:0]              read_data2,
   output logic [$clog2(DEPTH):0]   pending
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [4:0]    rd_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          push;
   logic          pop;
   logic [AW-1:0] idx;

   // ---------------------------------------------------------------------------
   // Handshake and drain control
   // ---------------------------------------------------------------------------
   always_comb begin
      RegWrite = !reset && !flush && !hold && (count != '0);
      // A pop in the same cycle frees a slot, so a full buffer may still accept.
      in_ready = !reset && !flush && ((count < FULL_COUNT) || RegWrite);
      // x0 writes are handshaken but never stored.
      push     = in_valid && in_ready && (in_rd != 5'd0);
      pop      = RegWrite;
   end

   assign Rd         = rd_mem[rd_ptr];
   assign Write_data = data_mem[rd_ptr];
   assign pending    = count;

   // ---------------------------------------------------------------------------
   // Pointers and occupancy
   // ---------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; an entry is only ever read while
   // count says it is valid, so clearing it would cost flops and buy nothing.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr]   <= in_rd;
         data_mem[wr_ptr] <= in_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Read forwarding
   //   Walk valid entries from head (oldest) to tail (youngest); a later match
   //   overrides an earlier one, so the youngest write to RsN wins. The request
   //   being accepted this cycle is not in the array yet and is not forwarded.
   // ---------------------------------------------------------------------------
   // NOTE: every output of this block gets a default first so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      read_data1 = rf_read_data1;
      read_data2 = rf_read_data2;
      idx        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if (CW'(i) < count) begin
            if (rd_mem[idx] == Rs1) read_data1 = data_mem[idx];
            if (rd_mem[idx] == Rs2) read_data2 = data_mem[idx];
         end
      end
      if (Rs1 == 5'd0) read_data1 = '0;
      if (Rs2 == 5'd0) read_data2 = '0;
   end

endmodule

// File: tb/tb_reg_writeback_buffer.sv
module tb_reg_writeback_buffer;

   localparam int DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   in_valid;
   logic                   in_ready;
   logic [4:0]             in_rd;
   logic [31:0]            in_data;
   logic                   hold;
   logic                   flush;
   logic                   RegWrite;
   logic [4:0]             Rd;
   logic [31:0]            Write_data;
   logic [4:0]             Rs1;
   logic [4:0]             Rs2;
   logic [31:0]            rf_read_data1;
   logic [31:0]            rf_read_data2;
   logic [31:0]            read_data1;
   logic [31:0]            read_data2;
   logic [$clog2(DEPTH):0] pending;

   reg_writeback_buffer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rd         (in_rd),
      .in_data       (in_data),
      .hold          (hold),
      .flush         (flush),
      .RegWrite      (RegWrite),
      .Rd            (Rd),
      .Write_data    (Write_data),
      .Rs1           (Rs1),
      .Rs2           (Rs2),
      .rf_read_data1 (rf_read_data1),
      .rf_read_data2 (rf_read_data2),
      .read_data1    (read_data1),
      .read_data2    (read_data2),
      .pending       (pending)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue of outstanding writes, oldest first.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   wb_t model_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] rs, input logic [31:0] rf);
      if (rs == 5'd0) return 32'h0;
      for (int i = model_q.size() - 1; i >= 0; i--)
         if (model_q[i].rd == rs) return model_q[i].data;
      return rf;
   endfunction

   // One clock cycle: drive inputs, check outputs at the falling edge, then
   // advance the model at the rising edge.
   task automatic cycle(input logic v, input logic [4:0] rd, input logic [31:0] d,
                        input logic h, input logic f, input logic r,
                        input logic [4:0] s1, input logic [4:0] s2);
      bit exp_rw;
      bit exp_rdy;
      in_valid      = v;
      in_rd         = rd;
      in_data       = d;
      hold          = h;
      flush         = f;
      reset         = r;
      Rs1           = s1;
      Rs2           = s2;
      rf_read_data1 = $urandom;
      rf_read_data2 = $urandom;
      exp_rw  = (model_q.size() != 0) && !h && !f && !r;
      exp_rdy = !r && !f && ((model_q.size() < DEPTH) || exp_rw);
      @(negedge clk);
      check("in_ready", in_ready, exp_rdy);
      check("RegWrite", RegWrite, exp_rw);
      check("pending", pending, model_q.size());
      if (exp_rw) begin
         check("Rd", Rd, model_q[0].rd);
         check("Write_data", Write_data, model_q[0].data);
      end
      check("read_data1", read_data1, model_read(s1, rf_read_data1));
      check("read_data2", read_data2, model_read(s2, rf_read_data2));
      @(posedge clk);
      if (r || f) begin
         model_q.delete();
      end else begin
         if (exp_rw) void'(model_q.pop_front());
         if (v && exp_rdy && (rd != 5'd0)) model_q.push_back('{rd: rd, data: d});
      end
      #1;
   endtask

   task automatic idle(input logic h, input logic [4:0] s1, input logic [4:0] s2);
      cycle(1'b0, 5'd0, 32'h0, h, 1'b0, 1'b0, s1, s2);
   endtask

   initial begin
      in_valid = 0; in_rd = 0; in_data = 0; hold = 0; flush = 0;
      Rs1 = 0; Rs2 = 0; rf_read_data1 = 0; rf_read_data2 = 0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
      check("reset_pending", pending, 0);

      // First cycle out of reset, then single write latency.
      cycle(1'b1, 5'd3, 32'hABCDEF01, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0);
      check("lat_regwrite", RegWrite, 1);
      check("lat_rd", Rd, 3);
      check("lat_data", Write_data, 32'hABCDEF01);
      idle(1'b0, 5'd3, 5'd0);
      check("lat_pending", pending, 0);

      // Fill under hold, forward the youngest rd=5 write.
      cycle(1'b1, 5'd5, 32'h12345678, 1'b1, 1'b0, 1'b0, 5'd5, 5'd8);
      cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd5, 5'd8);
      cycle(1'b1, 5'd8, 32'hCAFE0001, 1'b1, 1'b0, 1'b0, 5'd5, 5'd8);
      cycle(1'b1, 5'd9, 32'h00000007, 1'b1, 1'b0, 1'b0, 5'd5, 5'd9);
      check("full_pending", pending, 4);
      check("full_ready", in_ready, 0);
      idle(1'b1, 5'd5, 5'd9);
      check("fwd_youngest", read_data1, 32'hDEADBEEF);

      // Release hold with a request: pop and push in the same cycle.
      cycle(1'b1, 5'd10, 32'h000000AA, 1'b0, 1'b0, 1'b0, 5'd10, 5'd5);
      check("popush_pending", pending, 4);
      for (int i = 0; i < 5; i++) idle(1'b0, 5'd10, 5'd5);
      check("drained_pending", pending, 0);

      // x0 request is consumed but never written.
      cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      check("x0_pending", pending, 0);
      idle(1'b0, 5'd0, 5'd0);

      // Flush with three entries buffered.
      cycle(1'b1, 5'd6, 32'h66666666, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7);
      cycle(1'b1, 5'd7, 32'h77777777, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7);
      cycle(1'b1, 5'd6, 32'h66660002, 1'b1, 1'b0, 1'b0, 5'd6, 5'd7);
      cycle(1'b1, 5'd4, 32'h44444444, 1'b1, 1'b1, 1'b0, 5'd6, 5'd7);
      check("flush_pending", pending, 0);
      for (int i = 0; i < 3; i++) idle(1'b0, 5'd6, 5'd7);

      // Reset with two entries buffered.
      cycle(1'b1, 5'd12, 32'hC0C0C0C0, 1'b1, 1'b0, 1'b0, 5'd12, 5'd13);
      cycle(1'b1, 5'd13, 32'hD0D0D0D0, 1'b1, 1'b0, 1'b0, 5'd12, 5'd13);
      cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd12, 5'd13);
      check("rst_mid_pending", pending, 0);
      for (int i = 0; i < 3; i++) idle(1'b0, 5'd12, 5'd13);

      // Randomized traffic; small rd range so forwarding hits often.
      for (int n = 0; n < 3000; n++) begin
         cycle($urandom_range(0, 9) < 7,
               5'($urandom_range(0, 7)),
               $urandom,
               $urandom_range(0, 9) < 3,
               $urandom_range(0, 24) == 0,
               $urandom_range(0, 59) == 0,
               5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
